fc_pe_ctrl: RTL and testbench
=============================

Name: fc_pe_ctrl

Overview:
- Sequencer for the 1x120 fully-connected PE chain.
- Per output neuron it:
  - fetches that neuron's 120-weight row from the weight buffer and pulses the chain's load strobe;
  - streams 120 ifmap bytes from the ifmap buffer into the chain;
  - waits out the chain pipeline, then captures the 32-bit psum and hands it downstream over a valid/ready handshake.
- Repeats for num_out_i neurons, then pulses done.

Parameters:
- FC_SIZE, 120, PE count = input vector length per pass
- PIPE_LAT, 121, cycles from the last ifmap byte presented to the chain until psum_i holds the final dot product
- NEUR_W, 8, width of the neuron count/index

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  start a layer; sampled only in IDLE
- num_out_i  in  NEUR_W  number of output neurons; latched at start
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse when the layer completes
- wbuf_rd_o  out  1  weight-row read strobe; buffer returns the row 1 cycle later
- wbuf_addr_o  out  NEUR_W  neuron index of the row being read
- pe_load_o  out  1  weight-load strobe to the chain; the chain adds its own 1-cycle delay
- ifbuf_rd_o  out  1  ifmap read strobe; data reaches the chain input 1 cycle later
- ifbuf_addr_o  out  $clog2(FC_SIZE)  ifmap element index 0..FC_SIZE-1
- psum_i  in  32  psum_o of the chain
- res_valid_o  out  1  result valid
- res_ready_i  in  1  downstream accept
- res_data_o  out  32  captured dot product
- res_idx_o  out  NEUR_W  neuron index of res_data_o

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all counters 0.

FSM, one state per cycle unless stated:
- IDLE
  - start_i=1 and num_out_i!=0: latch num_out_i, neuron counter n=0, go to WREQ.
  - start_i=1 and num_out_i==0: done_o=1 on the next cycle, no buffer reads, stay IDLE.
- WREQ: wbuf_rd_o=1, wbuf_addr_o=n; go to WLOAD.
- WLOAD: pe_load_o=1 for exactly 1 cycle; go to STREAM with k=0.
- STREAM: ifbuf_rd_o=1, ifbuf_addr_o=k, one read per cycle with no bubbles.
  - k==FC_SIZE-1: go to DRAIN with d=0.
  - Otherwise k++.
- DRAIN: d counts from 0.
  - The last byte reaches the chain 1 cycle after the last read.
  - At d==PIPE_LAT: capture psum_i into res_data_o, n into res_idx_o; go to OUT.
  - DRAIN therefore lasts PIPE_LAT+1 cycles.
- OUT: res_valid_o=1; res_data_o and res_idx_o held stable until res_ready_i=1.
  - On acceptance, res_valid_o drops the next cycle.
  - If n==num_out-1: done_o pulses in that next cycle, then IDLE.
  - Else n++ and go to WREQ.
  - res_ready_i may be high when OUT is entered: accept in that first cycle.

Timing:
- Pass length (ready always high) = 1 (WREQ) + 1 (WLOAD) + FC_SIZE + PIPE_LAT+1 + 1 (OUT) = 245 cycles at defaults.

Boundary rules:
- start_i while busy: ignored. num_out_i changes mid-layer: no effect (latched).
- res_ready_i held low indefinitely: stall in OUT; the next pass is not started, so no result is ever overwritten.
- ifbuf_addr_o wraps to 0 only on a new pass, never mid-stream.
- rst_n asserted mid-operation: immediate return to IDLE; strobes and res_valid_o drop asynchronously; no done_o.
- num_out_i=2^NEUR_W-1: n reaches 254 without overflow.
- Width checks: ifbuf_addr_o width holds FC_SIZE-1; drain counter width $clog2(PIPE_LAT+1).

Decomposition:
- Package fc_pkg:
  - localparams FC_SIZE and FC_PIPE_LAT;
  - state enum fc_state_e {IDLE, WREQ, WLOAD, STREAM, DRAIN, OUT};
  - the PSUM_W=32 constant.
- Single module.
- The valid/ready result register is natural as a sub-module fc_res_reg (capture, hold until ready).

Test Plan:
- num_out=1, res_ready_i tied 1:
  - wbuf_rd_o at cycle 1 after start, pe_load_o at cycle 2, ifbuf_addr_o 0..119 on cycles 3..122;
  - res_valid_o for exactly 1 cycle at cycle 245 (at defaults; derive from the OUT timing above);
  - done_o the cycle after; busy_o low afterwards.
- num_out=3, chain model = dot product with weights all 1 and ifmap all 2:
  - three results of 240 with res_idx_o 0,1,2;
  - wbuf_addr_o 0,1,2;
  - done_o exactly once.
- Backpressure: num_out=2, hold res_ready_i low for 50 cycles in OUT:
  - res_data_o and res_idx_o stable throughout;
  - no WREQ until acceptance;
  - second pass starts the cycle after acceptance.
- num_out=0: done_o one cycle after start; wbuf_rd_o and ifbuf_rd_o never assert.
- start_i pulsed during STREAM: ignored, counters unaffected.
  - rst_n low at k=60: all outputs 0 immediately;
  - a fresh start afterwards completes normally with ifbuf_addr_o starting at 0.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared constants and state encoding for the fully-connected PE chain sequencer.
package fc_pkg;

    // Number of PEs in the chain, which is also the input vector length per pass.
    localparam int FC_SIZE     = 120;
    // Cycles from the last ifmap byte reaching the chain until psum is final.
    localparam int FC_PIPE_LAT = 121;
    // Width of the chain's partial-sum output.
    localparam int PSUM_W      = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WREQ   = 3'd1,
        WLOAD  = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        OUT    = 3'd5
    } fc_state_e;

    // Pass length in cycles when the result is accepted on its first OUT cycle.
    function automatic int fc_pass_cycles(input int size, input int lat);
        return 1 + 1 + size + (lat + 1) + 1;
    endfunction

endpackage

// File: rtl/fc_res_reg.sv
// Result holding register with a valid/ready handshake: captures a dot product
// and its neuron index, then holds both stable until downstream accepts.
module fc_res_reg
    import fc_pkg::*;
#(
    parameter int DATA_W = PSUM_W,
    parameter int IDX_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cap_i,
    input  logic signed [DATA_W-1:0] data_i,
    input  logic        [IDX_W-1:0]  idx_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic signed [DATA_W-1:0] data_o,
    output logic        [IDX_W-1:0]  idx_o,
    output logic                     accept_o
);

    logic                     valid_q, valid_d;
    logic signed [DATA_W-1:0] data_q, data_d;
    logic        [IDX_W-1:0]  idx_q, idx_d;

    // A capture loads the payload; an accepted handshake drops valid.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        if (cap_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            idx_d   = idx_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Result register; cleared asynchronously so valid never lingers through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
        end
    end

    assign valid_o  = valid_q;
    assign data_o   = data_q;
    assign idx_o    = idx_q;
    assign accept_o = valid_q & ready_i;

endmodule

// File: rtl/fc_pe_ctrl.sv
// Sequencer for the 1xFC_SIZE fully-connected PE chain: per output neuron it
// loads the weight row, streams the ifmap, waits out the chain pipeline and
// hands the captured psum downstream, then pulses done after the last neuron.
module fc_pe_ctrl
    import fc_pkg::*;
#(
    parameter int FC_SIZE  = fc_pkg::FC_SIZE,
    parameter int PIPE_LAT = fc_pkg::FC_PIPE_LAT,
    parameter int NEUR_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic [NEUR_W-1:0]            num_out_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         wbuf_rd_o,
    output logic [NEUR_W-1:0]            wbuf_addr_o,
    output logic                         pe_load_o,
    output logic                         ifbuf_rd_o,
    output logic [$clog2(FC_SIZE)-1:0]   ifbuf_addr_o,
    input  logic signed [PSUM_W-1:0]     psum_i,
    output logic                         res_valid_o,
    input  logic                         res_ready_i,
    output logic signed [PSUM_W-1:0]     res_data_o,
    output logic [NEUR_W-1:0]            res_idx_o
);

    localparam int ADDR_W  = $clog2(FC_SIZE);
    localparam int DRAIN_W = $clog2(PIPE_LAT + 1);

    localparam logic [ADDR_W-1:0]  K_LAST = ADDR_W'(FC_SIZE - 1);
    localparam logic [DRAIN_W-1:0] D_LAST = DRAIN_W'(PIPE_LAT);

    fc_state_e          state_q, state_d;
    logic [NEUR_W-1:0]  n_q, n_d;
    logic [NEUR_W-1:0]  num_q, num_d;
    logic [ADDR_W-1:0]  k_q, k_d;
    logic [DRAIN_W-1:0] d_q, d_d;
    logic               done_q, done_d;
    logic               cap;
    logic               res_accept;

    // Next-state logic: one state per cycle except STREAM, DRAIN and a stalled OUT.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        num_d   = num_q;
        k_d     = k_q;
        d_d     = d_q;
        done_d  = 1'b0;
        cap     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (num_out_i != '0) begin
                        num_d   = num_out_i;
                        n_d     = '0;
                        state_d = WREQ;
                    end else begin
                        // Empty layer: report completion without touching the buffers.
                        done_d = 1'b1;
                    end
                end
            end
            WREQ: begin
                state_d = WLOAD;
            end
            WLOAD: begin
                k_d     = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    d_d     = '0;
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (d_q == D_LAST) begin
                    // psum_i now holds the final dot product of this pass.
                    cap     = 1'b1;
                    d_d     = '0;
                    state_d = OUT;
                end else begin
                    d_d = d_q + DRAIN_W'(1);
                end
            end
            OUT: begin
                // Stay here until accepted so a pending result is never overwritten.
                if (res_accept) begin
                    if (n_q == num_q - NEUR_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        n_d     = n_q + NEUR_W'(1);
                        state_d = WREQ;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            num_q   <= '0;
            k_q     <= '0;
            d_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            num_q   <= num_d;
            k_q     <= k_d;
            d_q     <= d_d;
            done_q  <= done_d;
        end
    end

    // Strobes and addresses decode straight from the state so reset clears them at once.
    always_comb begin
        busy_o       = (state_q != IDLE);
        wbuf_rd_o    = (state_q == WREQ);
        wbuf_addr_o  = (state_q == WREQ) ? n_q : '0;
        pe_load_o    = (state_q == WLOAD);
        ifbuf_rd_o   = (state_q == STREAM);
        ifbuf_addr_o = (state_q == STREAM) ? k_q : '0;
        done_o       = done_q;
    end

    fc_res_reg #(
        .DATA_W (PSUM_W),
        .IDX_W  (NEUR_W)
    ) u_res_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .cap_i    (cap),
        .data_i   (psum_i),
        .idx_i    (n_q),
        .ready_i  (res_ready_i),
        .valid_o  (res_valid_o),
        .data_o   (res_data_o),
        .idx_o    (res_idx_o),
        .accept_o (res_accept)
    );

endmodule

// File: tb/tb_fc_pe_ctrl.sv
// Bench for fc_pe_ctrl: a buffer/chain model drives psum_i, and a pass-timeline
// reference model predicts every control output cycle by cycle.
module tb_fc_pe_ctrl;
    import fc_pkg::*;

    localparam int NEUR_W = 8;
    localparam int AW     = $clog2(FC_SIZE);
    // Offset of the OUT cycle within a pass (WREQ is offset 0).
    localparam int T_OUT  = fc_pass_cycles(FC_SIZE, FC_PIPE_LAT) - 1;

    logic                     clk;
    logic                     rst_n;
    logic                     start_i;
    logic [NEUR_W-1:0]        num_out_i;
    logic                     busy_o;
    logic                     done_o;
    logic                     wbuf_rd_o;
    logic [NEUR_W-1:0]        wbuf_addr_o;
    logic                     pe_load_o;
    logic                     ifbuf_rd_o;
    logic [AW-1:0]            ifbuf_addr_o;
    logic signed [PSUM_W-1:0] psum_i;
    logic                     res_valid_o;
    logic                     res_ready_i;
    logic signed [PSUM_W-1:0] res_data_o;
    logic [NEUR_W-1:0]        res_idx_o;

    fc_pe_ctrl #(
        .FC_SIZE  (FC_SIZE),
        .PIPE_LAT (FC_PIPE_LAT),
        .NEUR_W   (NEUR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .num_out_i    (num_out_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .wbuf_rd_o    (wbuf_rd_o),
        .wbuf_addr_o  (wbuf_addr_o),
        .pe_load_o    (pe_load_o),
        .ifbuf_rd_o   (ifbuf_rd_o),
        .ifbuf_addr_o (ifbuf_addr_o),
        .psum_i       (psum_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_data_o   (res_data_o),
        .res_idx_o    (res_idx_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Weight rows and ifmap vector held by the buffers.
    logic [7:0] wmem [0:255][0:FC_SIZE-1];
    logic [7:0] ifm  [0:FC_SIZE-1];

    function automatic logic [31:0] ref_dot(input int n);
        logic [31:0] s = 32'd0;
        for (int i = 0; i < FC_SIZE; i++) s += 32'(wmem[n][i]) * 32'(ifm[i]);
        return s;
    endfunction

    task automatic fill(input bit ones_twos);
        for (int r = 0; r < 256; r++)
            for (int i = 0; i < FC_SIZE; i++)
                wmem[r][i] = ones_twos ? 8'd1 : 8'($urandom);
        for (int i = 0; i < FC_SIZE; i++) ifm[i] = ones_twos ? 8'd2 : 8'($urandom);
    endtask

    // Buffer + chain model: accumulates whatever the sequencer actually streams
    // with whatever row it actually loaded; psum is garbage until the pipeline settles.
    int          row_pend = 0;
    int          row_live = 0;
    int          ready_at = 1 << 30;
    logic [31:0] acc      = 32'd0;
    always @(negedge clk) begin
        if (!rst_n) begin
            ready_at = 1 << 30;
            acc      = 32'd0;
            psum_i   = $urandom;
        end else begin
            if (wbuf_rd_o) row_pend = int'(wbuf_addr_o);
            if (pe_load_o) row_live = row_pend;
            if (ifbuf_rd_o) begin
                if (ifbuf_addr_o == '0) begin
                    acc      = 32'd0;
                    ready_at = 1 << 30;
                end
                acc += 32'(wmem[row_live][ifbuf_addr_o]) * 32'(ifm[ifbuf_addr_o]);
                // Byte reaches the chain next cycle, result settles PIPE_LAT later.
                if (ifbuf_addr_o == AW'(FC_SIZE - 1)) ready_at = cyc + 1 + FC_PIPE_LAT;
            end
            psum_i = (cyc >= ready_at) ? acc : $urandom;
        end
    end

    // Reference model: a layer is a sequence of passes on a timeline where offset 0
    // reads weights, 1 loads, 2..FC_SIZE+1 stream, and T_OUT waits for acceptance.
    bit m_busy    = 1'b0;
    int m_t       = 0;
    int m_n       = 0;
    int m_num     = 0;
    int m_done_at = -1;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy    = 1'b0;
            m_t       = 0;
            m_n       = 0;
            m_num     = 0;
            m_done_at = -1;
        end else begin
            chk("busy", busy_o, m_busy);
            chk("done", done_o, cyc == m_done_at);
            chk("wbuf_rd", wbuf_rd_o, m_busy && m_t == 0);
            if (m_busy && m_t == 0) chk("wbuf_addr", wbuf_addr_o, m_n);
            chk("pe_load", pe_load_o, m_busy && m_t == 1);
            chk("ifbuf_rd", ifbuf_rd_o, m_busy && m_t >= 2 && m_t < 2 + FC_SIZE);
            if (m_busy && m_t >= 2 && m_t < 2 + FC_SIZE) chk("ifbuf_addr", ifbuf_addr_o, m_t - 2);
            chk("res_valid", res_valid_o, m_busy && m_t == T_OUT);
            if (m_busy && m_t == T_OUT) begin
                chk("res_idx", res_idx_o, m_n);
                chk("res_data", res_data_o, ref_dot(m_n));
            end
            if (!m_busy) begin
                if (start_i) begin
                    if (num_out_i == '0) begin
                        m_done_at = cyc + 1;
                    end else begin
                        m_busy = 1'b1;
                        m_num  = int'(num_out_i);
                        m_n    = 0;
                        m_t    = 0;
                    end
                end
            end else if (m_t < T_OUT) begin
                m_t++;
            end else if (res_ready_i) begin
                if (m_n == m_num - 1) begin
                    m_busy    = 1'b0;
                    m_done_at = cyc + 1;
                end else begin
                    m_n++;
                    m_t = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_strobes"}, {wbuf_rd_o, pe_load_o, ifbuf_rd_o, res_valid_o}, 0);
        chk({tag, "_addrs"}, {wbuf_addr_o, ifbuf_addr_o}, 0);
        chk({tag, "_res"}, {res_data_o, res_idx_o}, 0);
    endtask

    // Start a layer and wait for done; rmode 1 randomizes res_ready_i each cycle.
    task automatic run_layer(input int num, input bit rmode);
        bit seen = 1'b0;
        int budget = num * 800 + 20;
        start_i   = 1'b1;
        num_out_i = NEUR_W'(num);
        tick();
        start_i   = 1'b0;
        num_out_i = NEUR_W'($urandom);
        for (int i = 0; i < budget; i++) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            if (rmode) res_ready_i = 1'($urandom_range(0, 1));
            tick();
        end
        res_ready_i = 1'b1;
        chk("layer_done_seen", seen, 1);
        tick();
    endtask

    task automatic wait_cond_addr(input int addr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (ifbuf_rd_o && ifbuf_addr_o == AW'(addr)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        bit ok;
        int wrd_at, wrd_n, ld_at, if0_at, ifl_at, v_at, v_n, d_at, d_n;
        logic signed [PSUM_W-1:0] held_data;
        logic [NEUR_W-1:0]        held_idx;

        rst_n       = 1'b0;
        start_i     = 1'b0;
        num_out_i   = '0;
        res_ready_i = 1'b1;
        fill(1'b0);
        repeat (3) tick();
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        tick();

        // Single neuron with ready tied high: pass timeline offsets.
        start_i   = 1'b1;
        num_out_i = 8'd1;
        tick();
        start_i = 1'b0;
        wrd_at = -1; wrd_n = 0; ld_at = -1; if0_at = -1; ifl_at = -1;
        v_at = -1; v_n = 0; d_at = -1; d_n = 0;
        for (int off = 1; off <= 250; off++) begin
            if (wbuf_rd_o) begin wrd_n++; if (wrd_at < 0) wrd_at = off; end
            if (pe_load_o && ld_at < 0) ld_at = off;
            if (ifbuf_rd_o && ifbuf_addr_o == '0 && if0_at < 0) if0_at = off;
            if (ifbuf_rd_o && ifbuf_addr_o == AW'(FC_SIZE - 1)) ifl_at = off;
            if (res_valid_o) begin v_n++; v_at = off; end
            if (done_o) begin d_n++; d_at = off; end
            if (off < 250) tick();
        end
        chk("t1_wrd_at", wrd_at, 1);
        chk("t1_wrd_cnt", wrd_n, 1);
        chk("t1_load_at", ld_at, 2);
        chk("t1_if_first_at", if0_at, 3);
        chk("t1_if_last_at", ifl_at, 2 + FC_SIZE);
        chk("t1_valid_at", v_at, 245);
        chk("t1_valid_cnt", v_n, 1);
        chk("t1_done_at", d_at, 246);
        chk("t1_done_cnt", d_n, 1);
        chk("t1_busy_after", busy_o, 0);
        tick();

        // Three neurons, all-ones weights and all-twos ifmap: 240 each.
        fill(1'b1);
        chk("t2_ref_240", ref_dot(1), 240);
        run_layer(3, 1'b0);
        fill(1'b0);

        // Backpressure: two neurons, ready held low for 50 cycles in OUT.
        res_ready_i = 1'b0;
        start_i     = 1'b1;
        num_out_i   = 8'd2;
        tick();
        start_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (res_valid_o) begin ok = 1'b1; break; end
            tick();
        end
        chk("bp_valid_seen", ok, 1);
        held_data = res_data_o;
        held_idx  = res_idx_o;
        repeat (50) begin
            tick();
            chk("bp_data_stable", res_data_o, held_data);
            chk("bp_idx_stable", res_idx_o, held_idx);
            chk("bp_no_wreq", wbuf_rd_o, 0);
        end
        res_ready_i = 1'b1;
        tick();
        chk("bp_next_wreq", wbuf_rd_o, 1);
        chk("bp_next_addr", wbuf_addr_o, 1);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done_o) begin ok = 1'b1; break; end
            tick();
        end
        chk("bp_done_seen", ok, 1);
        tick();

        // Empty layer: done one cycle after start, no buffer traffic.
        start_i   = 1'b1;
        num_out_i = 8'd0;
        tick();
        start_i = 1'b0;
        chk("n0_done", done_o, 1);
        chk("n0_no_reads", {wbuf_rd_o, ifbuf_rd_o}, 0);
        tick();
        chk("n0_done_once", done_o, 0);
        tick();

        // start_i during STREAM is ignored, then reset mid-stream at k=60.
        start_i   = 1'b1;
        num_out_i = 8'd3;
        tick();
        start_i = 1'b0;
        wait_cond_addr(20, ok);
        chk("ign_reach_k20", ok, 1);
        start_i   = 1'b1;
        num_out_i = 8'd0;
        tick();
        start_i = 1'b0;
        wait_cond_addr(60, ok);
        chk("rst_reach_k60", ok, 1);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_layer(2, 1'b1);

        // Randomized layers with random backpressure.
        for (int l = 0; l < 4; l++) begin
            fill(1'b0);
            run_layer(int'($urandom_range(1, 4)), 1'b1);
        end

        // Largest neuron count.
        run_layer(255, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
